// File: rtl/rv_mem_pkg.sv
// Shared encodings for the byte-sequenced memory path (fetch + load/store).
package rv_mem_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;
  typedef enum logic {PORT_IF = 1'b0, PORT_D = 1'b1} port_e;

  // Beat count per access; the reserved size 2'b11 runs as a word.
  function automatic logic [2:0] beats(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/rv_load_ext.sv
// Sign/zero extension of assembled load data; shared with the LSU.
module rv_load_ext
  import rv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);
  always_comb begin
    data = word;
    case (size)
      SZ_B:    data = {{24{~is_unsigned & word[7]}},  word[7:0]};
      SZ_H:    data = {{16{~is_unsigned & word[15]}}, word[15:0]};
      default: data = word;
    endcase
  end
endmodule

// File: rtl/rv_mem_sequencer.sv
// Arbitrates fetch and data ports onto one byte-wide array, moving one
// little-endian byte per clock.
module rv_mem_sequencer
  import rv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [31:0]           if_addr,
  output logic                  if_rsp_valid,
  output logic [31:0]           if_rdata,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_we,
  input  logic [1:0]            d_size,
  input  logic                  d_unsigned,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_rsp_valid,
  output logic [31:0]           d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);
  state_e                state, state_n;
  port_e                 last_grant, port_q;
  logic                  we_q, uns_q;
  logic [1:0]            size_q, beat_q;
  logic [2:0]            nbeats_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, asm_q, asm_next, ext_data;
  logic                  pick_d, accept, last_beat, xfer;
  logic                  unused_hi;

  assign unused_hi = ^{if_addr[31:ADDR_WIDTH], d_addr[31:ADDR_WIDTH]};

  // Data wins a tie unless it was the previous grantee.
  assign pick_d       = d_req_valid && (!if_req_valid || last_grant == PORT_IF);
  assign d_req_ready  = (state == IDLE) && !rst && pick_d;
  assign if_req_ready = (state == IDLE) && !rst && if_req_valid && !pick_d;
  assign accept       = if_req_ready || d_req_ready;

  assign xfer      = (state == XFER);
  assign last_beat = ({1'b0, beat_q} == nbeats_q - 3'd1);

  // Gating with rst keeps an aborted beat from landing in the array.
  assign mem_we    = xfer && we_q && !rst;
  assign mem_addr  = xfer ? addr_q + ADDR_WIDTH'(beat_q) : '0;
  assign mem_wdata = (xfer && we_q) ? wdata_q[{beat_q, 3'b000} +: 8] : 8'h00;

  assign if_rsp_valid = (state == RESP) && (port_q == PORT_IF) && !rst;
  assign d_rsp_valid  = (state == RESP) && (port_q == PORT_D) && !rst;

  always_comb begin
    asm_next = asm_q;
    asm_next[{beat_q, 3'b000} +: 8] = mem_rdata;
  end

  rv_load_ext u_ext (
    .word        (asm_next),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (ext_data)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = XFER;
      XFER:    if (last_beat) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= PORT_IF;
      port_q     <= PORT_IF;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_W;
      nbeats_q   <= 3'd4;
      beat_q     <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (accept) begin
          port_q     <= d_req_ready ? PORT_D : PORT_IF;
          last_grant <= d_req_ready ? PORT_D : PORT_IF;
          we_q       <= d_req_ready && d_we;
          uns_q      <= d_req_ready && d_unsigned;
          size_q     <= d_req_ready ? d_size : SZ_W;
          nbeats_q   <= d_req_ready ? beats(d_size) : 3'd4;
          addr_q     <= d_req_ready ? d_addr[ADDR_WIDTH-1:0] : if_addr[ADDR_WIDTH-1:0];
          wdata_q    <= d_wdata;
          beat_q     <= 2'd0;
          asm_q      <= '0;
        end
        XFER: begin
          asm_q  <= asm_next;
          beat_q <= beat_q + 2'd1;
          // The last byte comes straight from the array, so results load from asm_next.
          if (last_beat) begin
            if (port_q == PORT_IF) if_rdata <= asm_next;
            else                   d_rdata  <= we_q ? 32'h0 : ext_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/rv_mem_sequencer.md
Name: rv_mem_sequencer

Overview:
- Shares one byte-wide memory array (8-bit entries, 2**ADDR_WIDTH deep, asynchronous read) between the instruction-fetch port and the load/store port of the core.
- Sequences every access as a little-endian run of single-byte beats, one per clock.
- Handles byte, half and word loads and stores, and sign/zero-extends load data.
- Sits between the core's fetch/LSU stages and the byte memory, replacing direct 4-byte combinational taps with a single-ported sequenced access.

Parameters:
ADDR_WIDTH, 12, byte-address width of the memory array; request addresses are truncated to the low ADDR_WIDTH bits.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
if_req_valid  in  1  fetch request; held until accepted
if_req_ready  out  1  fetch request accepted this cycle
if_addr  in  32  fetch byte address (always word access, read)
if_rsp_valid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  32  fetched word
d_req_valid  in  1  data request; held until accepted
d_req_ready  out  1  data request accepted this cycle
d_we  in  1  1 = store, 0 = load
d_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
d_unsigned  in  1  load zero-extend (1) / sign-extend (0); ignored for stores
d_addr  in  32  data byte address
d_wdata  in  32  store data; bytes taken LSB first
d_rsp_valid  out  1  one-cycle pulse: load data valid or store complete
d_rdata  out  32  extended load data; 0 for stores
mem_addr  out  ADDR_WIDTH  byte address to array
mem_we  out  1  byte write strobe
mem_wdata  out  8  byte to write
mem_rdata  in  8  combinational read data for mem_addr

Behaviour:
- States: IDLE, XFER, RESP.
- IDLE: readys are combinational.
  - Only one requester valid: it gets ready=1.
  - Both valid: grant goes to the port not granted last (last_grant register, reset value = fetch, so data wins the first tie). The loser sees ready=0.
  - Neither valid: both ready=0.
  - On accept: latch port, we, size, unsigned, address (truncated), wdata. Set beat count N = 1/2/4. Go to XFER.
- XFER, beat k = 0..N-1, one per cycle:
  - mem_addr = latched addr + k, modulo 2**ADDR_WIDTH (wraps at top of array).
  - Store: mem_we=1, mem_wdata = wdata byte k.
  - Load: mem_rdata captured into byte k of the assembly register at the clock edge.
  - After beat N-1, go to RESP.
- RESP: the owning port's rsp_valid=1 for exactly this cycle; rdata is stable only this cycle. Return to IDLE. No response backpressure.
- Latency: accept at cycle 0, beats in cycles 1..N, rsp_valid in cycle N+1. Word fetch = 6 cycles accept-to-accept minimum; byte access = 3.
- Readys are 0 outside IDLE. A request raised during XFER/RESP waits and is arbitrated in the next IDLE cycle.
- Extension: size byte uses bit 7, half uses bit 15. Sign-extend if d_unsigned=0, otherwise zero-fill. Word is passed through. if_rdata is never extended.
- Misalignment is permitted; bytes are simply consecutive addresses. No alignment exception.
- mem_we=0 in every state except store beats in XFER. mem_addr=0 and mem_wdata=0 when not in XFER.
- Reset (any state, including mid-XFER): next state IDLE, last_grant=fetch. All outputs 0: readys, rsp_valids, rdata, mem_we, mem_addr, mem_wdata. An aborted access produces no response. Bytes of a store already written stay written.
- Output registers: rdata registers hold their last value until the next RESP. Nothing drives X after reset.

Decomposition:
- Shared package rv_mem_pkg:
  - size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10.
  - state encoding IDLE/XFER/RESP.
  - port id constants PORT_IF/PORT_D.
- One natural sub-module: rv_load_ext, a combinational sign/zero extender taking the assembled word, size and unsigned flag. The LSU reuses it.

Test Plan:
- Array bytes 0x100..0x103 = 13 05 00 00; if_addr=0x100 -> if_rsp_valid in cycle 5 with if_rdata=0x00000513; mem_addr sequence 0x100,0x101,0x102,0x103.
- Load byte, signed, d_addr=0x20 holding 0x80 -> d_rdata=0xFFFFFF80. Same access with d_unsigned=1 -> 0x00000080. rsp_valid in cycle 2.
- Half load from 0xFFF/0x000, bytes 0x34 and 0x92, with ADDR_WIDTH=12 -> mem_addr wraps 0xFFF then 0x000. Signed result 0xFFFF9234; unsigned result 0x00009234.
- Word store d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we high 4 cycles, bytes EF,BE,AD,DE at 0x40..0x43. d_rsp_valid pulse with d_rdata=0. A following word load returns 0xDEADBEEF.
- Both requesters held valid continuously after reset -> grant order D, IF, D, IF. The losing ready is never asserted in the same cycle as the winner's.
- rst asserted during beat 2 of a word store -> next cycle state IDLE, mem_we=0, no d_rsp_valid. Bytes 0 and 1 are written, bytes 2 and 3 unchanged. A new request is accepted on the first cycle after rst falls.
